rv_div_unit: RTL
================

RV_DIV_UNIT -- requirements
Module: rv_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_valid, input, 1 bit: a request is present.
REQ-005 SHALL have port start_ready, output, 1 bit: the unit can accept a request.
REQ-006 SHALL have port a, input, XLEN bits: the dividend.
REQ-007 SHALL have port b, input, XLEN bits: the divisor.
REQ-008 SHALL have port div_op, input, 2 bits: 0=DIV, 1=DIVU, 2=REM, 3=REMU (equal to RISC-V funct3[1:0]).
REQ-009 SHALL have port result_valid, output, 1 bit: result is available.
REQ-010 SHALL have port result_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port result, output, XLEN bits: the quotient or remainder.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL drive start_ready=1 only in IDLE; a request is accepted on a clk edge with start_valid&&start_ready.
REQ-015 SHALL, on accept, register a, b and div_op, and SHALL take operand magnitudes for DIV/REM (signed); inputs are don't-care afterwards.
REQ-016 SHALL, in CALC, retire exactly one quotient bit per cycle using restoring shift-subtract, with a counter of clog2(XLEN) bits running XLEN cycles.
REQ-017 SHALL negate the quotient when the operand signs differ (DIV) and negate the remainder when the dividend is negative (REM), on the CALC->DONE transition.
REQ-018 SHALL hold result_valid=1 in DONE and hold result stable until result_ready=1, then SHALL return to IDLE on that edge.
REQ-019 SHALL make result_valid first high exactly XLEN+1 cycles after the accept edge for normal operands.
REQ-020 SHALL produce, for divide by zero, quotient all-ones and remainder = a for both signed and unsigned operations.
REQ-021 SHALL produce, for signed overflow (a=most-negative, b=-1), quotient = a and remainder 0.
REQ-022 SHALL ignore start_valid outside IDLE; no back-to-back accept occurs in the cycle result_ready completes.
REQ-023 SHALL keep result at 0 whenever result_valid=0.

Reset
REQ-024 SHALL, on rst_n=0 at any time (including mid-CALC), enter IDLE with start_ready=1, result_valid=0, result=0, busy=0 and counter=0, discarding the in-flight operation.

Configuration
REQ-025 SHALL provide macro RV_DIV_FAST_SPECIAL_EN: when defined, divide-by-zero and signed-overflow requests skip CALC and enter DONE on the edge after accept (result_valid one cycle after accept).
REQ-026 SHALL, without RV_DIV_FAST_SPECIAL_EN, pass those cases through the full XLEN-cycle CALC with identical final results (REQ-020/021).

Structure
REQ-027 SHALL place the div_op encodings and the FSM state enum in shared package rv_div_pkg.
REQ-028 SHALL implement one iteration (shift, trial subtract, restore select) in combinational sub-module rv_div_step.

Verification
REQ-029 SHALL cover DIVU a=100, b=7 -> result 14, result_valid exactly 65 cycles after accept (XLEN=64, macro off).
REQ-030 SHALL cover DIV a=-7, b=2 -> 0xFFFFFFFFFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFFFFFFFFFF.
REQ-031 SHALL cover DIV a=5, b=0 -> 0xFFFFFFFFFFFFFFFF; REMU a=5, b=0 -> 5; with the macro on, result_valid 1 cycle after accept.
REQ-032 SHALL cover DIV a=0x8000000000000000, b=0xFFFFFFFFFFFFFFFF -> 0x8000000000000000; REM -> 0.
REQ-033 SHALL cover result_ready held low 10 cycles in DONE -> result stable, start_ready=0; after result_ready=1, start_ready=1 on the next cycle.
REQ-034 SHALL cover rst_n pulsed low at CALC iteration 30 -> result_valid=0, result=0, busy=0 immediately; a new DIVU 9/3 then returns 3.

Source files
------------

// File: rtl/rv_div_pkg.sv
// rv_div_pkg -- shared definitions for the iterative RISC-V divider.
//   div_op_t : operation encodings (equal to RISC-V funct3[1:0])
//   state_t  : divider FSM states
package rv_div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rv_div_step.sv
// rv_div_step -- one restoring shift-subtract iteration (combinational).
// Ports:
//   rem      : in,  XLEN  partial remainder
//   quo      : in,  XLEN  dividend bits still to be consumed (MSB first),
//                         with retired quotient bits shifting in at the LSB
//   dvsr     : in,  XLEN  divisor magnitude
//   rem_next : out, XLEN  partial remainder after this iteration
//   quo_next : out, XLEN  shift register with the new quotient bit appended
module rv_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvsr,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // Shifted remainder needs one extra bit: rem < dvsr <= 2^XLEN-1.
    logic [XLEN:0] rem_sh;
    logic          fits;

    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        fits   = (rem_sh >= {1'b0, dvsr});
        if (fits) begin
            rem_next = XLEN'(rem_sh - {1'b0, dvsr});
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/rv_div_unit.sv
// rv_div_unit -- iterative RISC-V DIV/DIVU/REM/REMU unit, one quotient bit
// per cycle (restoring algorithm), valid/ready handshakes on both sides.
// Ports:
//   clk          : in,  clock (rising edge)
//   rst_n        : in,  asynchronous active-low reset
//   start_valid  : in,  request present
//   start_ready  : out, unit idle and able to accept a request
//   a, b         : in,  XLEN dividend / divisor
//   div_op       : in,  2-bit operation (0=DIV 1=DIVU 2=REM 3=REMU)
//   result_valid : out, result available
//   result_ready : in,  consumer accepts the result
//   result       : out, XLEN quotient or remainder (0 while not valid)
//   busy         : out, FSM not in IDLE
// Build option: define RV_DIV_FAST_SPECIAL_EN to finish divide-by-zero and
// signed-overflow requests one cycle after accept instead of iterating.
module rv_div_unit
    import rv_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      div_op,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             iter_done;

    // Operand / iteration registers (no reset needed: loaded on accept).
    logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, a_q;
    logic             rem_sel, neg_q, neg_r, div0, ovf;

    logic             accept, signed_op, fast_special;
    logic [XLEN-1:0]  mag_a, mag_b, step_rem, step_quo;
    logic [XLEN-1:0]  q_fix, r_fix, res_final;

    assign accept    = start_valid && start_ready;
    assign signed_op = (div_op == OP_DIV) || (div_op == OP_REM);
    assign mag_a     = (signed_op && a[XLEN-1]) ? ('0 - a) : a;
    assign mag_b     = (signed_op && b[XLEN-1]) ? ('0 - b) : b;

`ifdef RV_DIV_FAST_SPECIAL_EN
    assign fast_special = div0 || ovf;
`else
    assign fast_special = 1'b0;
`endif

    rv_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvsr     (dvsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Sign fix-up of the magnitude results, then the RISC-V special cases.
    // Signed overflow already falls out of the magnitude path, but the
    // divide-by-zero quotient would be wrongly negated for a negative a.
    always_comb begin
        q_fix = neg_q ? ('0 - quo_q) : quo_q;
        r_fix = neg_r ? ('0 - rem_q) : rem_q;
        if (div0) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (ovf) begin
            q_fix = a_q;
            r_fix = '0;
        end
        res_final = rem_sel ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q   <= '0;
            quo_q   <= mag_a;
            dvsr_q  <= mag_b;
            a_q     <= a;
            rem_sel <= div_op[1];
            neg_q   <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r   <= signed_op && a[XLEN-1];
            div0    <= (b == '0);
            ovf     <= signed_op && (a == MOST_NEG) && (b == '1);
        end else if (state == CALC && !iter_done) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
        end
    end

    // XLEN iteration cycles, then one more CALC cycle for the fix-up
    // transition into DONE (result_valid XLEN+1 cycles after accept).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            iter_done    <= 1'b0;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        state       <= CALC;
                        cnt         <= '0;
                        iter_done   <= 1'b0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                CALC: begin
                    if (fast_special || iter_done) begin
                        state        <= DONE;
                        result       <= res_final;
                        result_valid <= 1'b1;
                        cnt          <= '0;
                        iter_done    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            iter_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        result       <= '0;
                        start_ready  <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    start_ready  <= 1'b1;
                    result_valid <= 1'b0;
                    result       <= '0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
